puf_uart_ctrl: RTL and testbench

- Command sequencer between the UART pair (UART_RXD / UART_TXD) and the PUF core.
- Parses command bytes from the receiver and collects challenge bytes.
- Launches the PUF, waits for its response, then serialises a framed reply through the transmitter one byte at a time using the TXD DV/Done handshake.
- Sole owner of the TXD input side; no other block drives tx_DV/tx_Byte.

---
 rtl/puf_uart_ctrl.sv | 142 ++++++++++++++
 tb/tb_puf_uart_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_uart_ctrl.sv
// puf_uart_ctrl: command sequencer between the UART byte interfaces and the PUF core
module puf_uart_ctrl #(
    parameter int CHAL_BYTES   = 2,
    parameter int RESP_BYTES   = 2,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_DV,
    input  logic [7:0]              rx_Byte,
    output logic                    tx_DV,
    output logic [7:0]              tx_Byte,
    input  logic                    tx_Done,
    output logic                    puf_start,
    output logic [8*CHAL_BYTES-1:0] puf_challenge,
    input  logic                    puf_done,
    input  logic [8*RESP_BYTES-1:0] puf_response,
    output logic                    busy,
    output logic                    err
);
    localparam int IW = $clog2(CHAL_BYTES + 1);
    localparam int RW = $clog2(RESP_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] CMD_CHAL = 8'h3F;
    localparam logic [7:0] CMD_PING = 8'h50;
    localparam logic [7:0] ACK      = 8'hAB;
    localparam logic [7:0] ERR_BYTE = 8'hEE;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_CHAL = 3'd1;
    localparam logic [2:0] PUF_GO   = 3'd2;
    localparam logic [2:0] PUF_WAIT = 3'd3;
    localparam logic [2:0] TX_SEND  = 3'd4;
    localparam logic [2:0] TX_WAIT  = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [8*RESP_BYTES-1:0] resp_q, resp_d;
    logic [8*CHAL_BYTES-1:0] chal_q, chal_d;
    logic [7:0]              txb_q, txb_d;
    logic                    err_q, err_d;
    logic                    start_q, txdv_q;

    assign tx_DV         = txdv_q;
    assign tx_Byte       = txb_q;
    assign puf_start     = start_q;
    assign puf_challenge = chal_q;
    assign busy          = state_q != IDLE;
    assign err           = err_q;

    // Next-state logic: command decode, challenge capture, PUF wait with timeout, reply serialisation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        resp_d  = resp_q;
        chal_d  = chal_q;
        txb_d   = txb_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (rx_DV) begin
                if (rx_Byte == CMD_CHAL) begin
                    state_d = GET_CHAL;
                    idx_d   = '0;
                end else if (rx_Byte == CMD_PING) begin
                    state_d = TX_SEND;
                    txb_d   = ACK;
                    rem_d   = '0;
                end else begin
                    state_d = TX_SEND;
                    txb_d   = ERR_BYTE;
                    rem_d   = '0;
                    err_d   = 1'b1;
                end
            end
            GET_CHAL: if (rx_DV) begin
                chal_d[{idx_q, 3'b000} +: 8] = rx_Byte;
                idx_d   = idx_q + IW'(1);
                state_d = (idx_q == IW'(CHAL_BYTES - 1)) ? PUF_GO : GET_CHAL;
            end
            PUF_GO: begin
                tmr_d   = '0;
                state_d = PUF_WAIT;
            end
            // puf_done is checked first so it wins over a timeout in the same cycle
            PUF_WAIT: if (puf_done) begin
                resp_d  = puf_response;
                rem_d   = RW'(RESP_BYTES);
                txb_d   = ACK;
                state_d = TX_SEND;
            end else if (tmr_q == TW'(TIMEOUT_CLKS - 1)) begin
                rem_d   = '0;
                txb_d   = ERR_BYTE;
                err_d   = 1'b1;
                state_d = TX_SEND;
            end else begin
                tmr_d   = tmr_q + TW'(1);
            end
            TX_SEND: state_d = TX_WAIT;
            TX_WAIT: if (tx_Done) begin
                if (rem_q != '0) begin
                    txb_d   = resp_q[7:0];
                    resp_d  = resp_q >> 8;
                    rem_d   = rem_q - RW'(1);
                    state_d = TX_SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; start/tx pulses are registered one cycle behind their launching state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            rem_q   <= '0;
            resp_q  <= '0;
            chal_q  <= '0;
            txb_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            txdv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            resp_q  <= resp_d;
            chal_q  <= chal_d;
            txb_q   <= txb_d;
            err_q   <= err_d;
            start_q <= state_q == PUF_GO;
            txdv_q  <= state_q == TX_SEND;
        end
    end
endmodule

// File: tb/tb_puf_uart_ctrl.sv
// tb_puf_uart_ctrl: directed self-checking bench for puf_uart_ctrl
module tb_puf_uart_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rx_DV = 1'b0, tx_Done = 1'b0, puf_done = 1'b0;
    logic [7:0]  rx_Byte = 8'h00;
    logic [15:0] puf_response = 16'h0000;
    logic        tx_DV, puf_start, busy, err;
    logic [7:0]  tx_Byte;
    logic [15:0] puf_challenge;
    int vec = 0, miss = 0, cyc = 0, n_dv = 0, n_st = 0;

    puf_uart_ctrl #(.CHAL_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CLKS(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_DV(rx_DV), .rx_Byte(rx_Byte),
        .tx_DV(tx_DV), .tx_Byte(tx_Byte), .tx_Done(tx_Done),
        .puf_start(puf_start), .puf_challenge(puf_challenge),
        .puf_done(puf_done), .puf_response(puf_response),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tx_DV) n_dv++;
        if (puf_start) n_st++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rx(input logic [7:0] b, output int t);
        rx_Byte = b;
        rx_DV = 1'b1;
        t = cyc;
        tick();
        rx_DV = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] r, output int t);
        puf_response = r;
        puf_done = 1'b1;
        t = cyc;
        tick();
        puf_done = 1'b0;
    endtask

    task automatic pulse_txdone(output int t);
        tx_Done = 1'b1;
        t = cyc;
        tick();
        tx_Done = 1'b0;
    endtask

    task automatic wait_tx(output logic [7:0] b, output int at);
        at = -1;
        b = 8'h00;
        for (int i = 0; i < 60 && at < 0; i++) begin
            @(negedge clk);
            if (tx_DV) begin
                at = cyc;
                b = tx_Byte;
            end
        end
        tick();
    endtask

    task automatic wait_start(output int at);
        at = -1;
        for (int i = 0; i < 60 && at < 0; i++) begin
            @(negedge clk);
            if (puf_start) at = cyc;
        end
        tick();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        vec++; if (tx_DV !== 1'b0) begin miss++; $display("FAIL reset_tx_DV got %b want 0", tx_DV); end
        vec++; if (tx_Byte !== 8'h00) begin miss++; $display("FAIL reset_tx_Byte got %h want 00", tx_Byte); end
        vec++; if (puf_start !== 1'b0) begin miss++; $display("FAIL reset_puf_start got %b want 0", puf_start); end
        vec++; if (puf_challenge !== 16'h0000) begin miss++; $display("FAIL reset_challenge got %h want 0000", puf_challenge); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL reset_err got %b want 0", err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_chal;
        logic [7:0] ex [3];
        logic [7:0] b;
        int t, at, st0, dv0;
        ex = '{8'hAB, 8'hEF, 8'hBE};
        st0 = n_st;
        dv0 = n_dv;
        pulse_rx(8'h3F, t);
        pulse_rx(8'h12, t);
        pulse_rx(8'h34, t);
        wait_start(at);
        vec++; if (at - t !== 2) begin miss++; $display("FAIL chal_start_latency got %0d want 2", at - t); end
        vec++; if (puf_challenge !== 16'h3412) begin miss++; $display("FAIL chal_challenge got %h want 3412", puf_challenge); end
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL chal_busy got %b want 1", busy); end
        pulse_done(16'hBEEF, t);
        for (int k = 0; k < 3; k++) begin
            wait_tx(b, at);
            vec++; if (b !== ex[k]) begin miss++; $display("FAIL chal_byte%0d got %h want %h", k, b, ex[k]); end
            vec++; if (at - t !== 2) begin miss++; $display("FAIL chal_tx_latency%0d got %0d want 2", k, at - t); end
            repeat (3) begin
                @(negedge clk);
                vec++; if (tx_DV !== 1'b0 || tx_Byte !== ex[k]) begin miss++; $display("FAIL chal_hold%0d got dv=%b byte=%h want dv=0 byte=%h", k, tx_DV, tx_Byte, ex[k]); end
            end
            tick();
            pulse_txdone(t);
        end
        repeat (3) tick();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL chal_idle_busy got %b want 0", busy); end
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL chal_err got %b want 0", err); end
        vec++; if (n_st - st0 !== 1) begin miss++; $display("FAIL chal_start_count got %0d want 1", n_st - st0); end
        vec++; if (n_dv - dv0 !== 3) begin miss++; $display("FAIL chal_tx_count got %0d want 3", n_dv - dv0); end
    endtask

    task automatic test_ping(input logic exp_err);
        logic [7:0] b;
        int t, at, st0, dv0;
        st0 = n_st;
        dv0 = n_dv;
        pulse_rx(8'h50, t);
        wait_tx(b, at);
        vec++; if (b !== 8'hAB) begin miss++; $display("FAIL ping_byte got %h want ab", b); end
        vec++; if (at - t !== 2) begin miss++; $display("FAIL ping_latency got %0d want 2", at - t); end
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL ping_busy got %b want 1", busy); end
        pulse_txdone(t);
        repeat (4) tick();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL ping_idle got %b want 0", busy); end
        vec++; if (n_st - st0 !== 0) begin miss++; $display("FAIL ping_no_start got %0d want 0", n_st - st0); end
        vec++; if (n_dv - dv0 !== 1) begin miss++; $display("FAIL ping_tx_count got %0d want 1", n_dv - dv0); end
        vec++; if (err !== exp_err) begin miss++; $display("FAIL ping_err got %b want %b", err, exp_err); end
    endtask

    task automatic test_unknown;
        logic [7:0] b;
        int t, at, dv0;
        dv0 = n_dv;
        pulse_rx(8'h77, t);
        wait_tx(b, at);
        vec++; if (b !== 8'hEE) begin miss++; $display("FAIL unk_byte got %h want ee", b); end
        vec++; if (err !== 1'b1) begin miss++; $display("FAIL unk_err got %b want 1", err); end
        pulse_txdone(t);
        repeat (3) tick();
        vec++; if (n_dv - dv0 !== 1) begin miss++; $display("FAIL unk_tx_count got %0d want 1", n_dv - dv0); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL unk_idle got %b want 0", busy); end
        test_ping(1'b1);
    endtask

    task automatic test_timeout;
        logic [7:0] ex [3];
        logic [7:0] b;
        int t, at, ts;
        ex = '{8'hAB, 8'h34, 8'h12};
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL to_pre_err got %b want 0", err); end
        pulse_rx(8'h3F, t);
        pulse_rx(8'h01, t);
        pulse_rx(8'h02, t);
        wait_start(ts);
        wait_tx(b, at);
        vec++; if (b !== 8'hEE) begin miss++; $display("FAIL to_byte got %h want ee", b); end
        vec++; if (at - ts !== 17) begin miss++; $display("FAIL to_latency got %0d want 17", at - ts); end
        vec++; if (err !== 1'b1) begin miss++; $display("FAIL to_err got %b want 1", err); end
        vec++; if (puf_challenge !== 16'h0201) begin miss++; $display("FAIL to_challenge got %h want 0201", puf_challenge); end
        pulse_txdone(t);
        repeat (3) tick();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL to_idle got %b want 0", busy); end
        pulse_rx(8'h3F, t);
        pulse_rx(8'hAA, t);
        pulse_rx(8'h55, t);
        wait_start(ts);
        while (cyc < ts + 15) tick();
        pulse_done(16'h1234, t);
        for (int k = 0; k < 3; k++) begin
            wait_tx(b, at);
            vec++; if (b !== ex[k]) begin miss++; $display("FAIL to_edge_byte%0d got %h want %h", k, b, ex[k]); end
            pulse_txdone(t);
        end
        repeat (3) tick();
        vec++; if (err !== 1'b1) begin miss++; $display("FAIL to_edge_err got %b want 1", err); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL to_edge_idle got %b want 0", busy); end
    endtask

    task automatic test_extra_rx;
        logic [7:0] ex [3];
        logic [7:0] b;
        int t, tx, at, dv0;
        ex = '{8'hAB, 8'hFE, 8'hCA};
        dv0 = n_dv;
        pulse_rx(8'h3F, t);
        pulse_rx(8'h11, t);
        pulse_rx(8'h22, t);
        wait_start(at);
        pulse_rx(8'h55, tx);
        pulse_done(16'hCAFE, t);
        for (int k = 0; k < 3; k++) begin
            wait_tx(b, at);
            vec++; if (b !== ex[k]) begin miss++; $display("FAIL extra_byte%0d got %h want %h", k, b, ex[k]); end
            pulse_rx(8'h55, tx);
            puf_done = 1'b1;
            tick();
            puf_done = 1'b0;
            vec++; if (tx_Byte !== ex[k]) begin miss++; $display("FAIL extra_hold%0d got %h want %h", k, tx_Byte, ex[k]); end
            pulse_txdone(t);
        end
        repeat (3) tick();
        vec++; if (n_dv - dv0 !== 3) begin miss++; $display("FAIL extra_tx_count got %0d want 3", n_dv - dv0); end
        vec++; if (puf_challenge !== 16'h2211) begin miss++; $display("FAIL extra_challenge got %h want 2211", puf_challenge); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL extra_idle got %b want 0", busy); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] b;
        int t, at, dv0;
        pulse_rx(8'h3F, t);
        pulse_rx(8'h01, t);
        pulse_rx(8'h02, t);
        wait_start(at);
        pulse_done(16'h5AC3, t);
        wait_tx(b, at);
        pulse_txdone(t);
        wait_tx(b, at);
        vec++; if (b !== 8'hC3) begin miss++; $display("FAIL mr_byte1 got %h want c3", b); end
        pulse_txdone(t);
        dv0 = n_dv;
        rst_n = 1'b0;
        #1;
        vec++; if (tx_DV !== 1'b0) begin miss++; $display("FAIL mr_tx_DV got %b want 0", tx_DV); end
        vec++; if (tx_Byte !== 8'h00) begin miss++; $display("FAIL mr_tx_Byte got %h want 00", tx_Byte); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL mr_busy got %b want 0", busy); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        vec++; if (n_dv - dv0 !== 0) begin miss++; $display("FAIL mr_no_tx got %0d want 0", n_dv - dv0); end
        test_ping(1'b0);
    endtask

    initial begin
        test_reset();
        test_chal();
        test_ping(1'b0);
        test_unknown();
        do_reset();
        test_timeout();
        test_extra_rx();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
